// File: rtl/demux_1xn_stream.sv
// Purpose : 1-to-N stream demultiplexer with unicast, broadcast and drop-on-bad-select.
// Latency : one cycle from input accept to out_valid/out_data.
// Backpr. : in_ready is high only when every pending channel is consumed this cycle.
//
// Ports
//   clk, rst_n          : single clock, asynchronous active-low reset
//   in_valid/in_ready   : upstream handshake
//   in_data             : payload (DATA_W bits)
//   in_sel              : destination channel index (SEL_W bits)
//   in_bcast            : deliver to all N_OUT channels, in_sel ignored
//   out_valid/out_ready : per-channel handshake (N_OUT bits each)
//   out_data            : held payload, shared by all channels
//   drop_cnt            : saturating count of words dropped for a bad select
module demux_1xn_stream #(
   parameter int DATA_W = 8,
   parameter int N_OUT  = 8,
   parameter int SEL_W  = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [SEL_W-1:0]  in_sel,
   input  logic              in_bcast,
   output logic [N_OUT-1:0]  out_valid,
   input  logic [N_OUT-1:0]  out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [7:0]        drop_cnt
);

   // The pending mask is the only state that defines the FSM; the enum is a
   // decoded view of it so no separate encoding can drift from the outputs.
   typedef enum logic {
      EMPTY = 1'b0,
      HOLD  = 1'b1
   } state_t;

   localparam logic [SEL_W:0] N_OUT_CMP = (SEL_W+1)'(N_OUT);
   localparam logic [N_OUT-1:0] ONE_LSB = N_OUT'(1);

   logic [N_OUT-1:0]  pend_q, pend_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [7:0]        drop_q, drop_d;

   state_t            state;
   logic [N_OUT-1:0]  still_blocked;
   logic              accept;
   logic              sel_ok;
   logic [N_OUT-1:0]  sel_onehot;

   assign state         = (pend_q != '0) ? HOLD : EMPTY;

   // Channels that hold a word and are not consuming it this cycle.
   assign still_blocked = pend_q & ~out_ready;

   // Full-rate: the last outstanding consumer and the next producer can
   // hand off in the same cycle.
   assign in_ready      = (state == EMPTY) || (still_blocked == '0);
   assign accept        = in_valid && in_ready;

   // Zero-extend the select so the range check also works when
   // 2**SEL_W == N_OUT.
   assign sel_ok        = ({1'b0, in_sel} < N_OUT_CMP);
   assign sel_onehot    = ONE_LSB << in_sel;

   always_comb begin
      // Default: retire the channels that are consuming; hold the rest.
      pend_d = still_blocked;
      data_d = data_q;
      drop_d = drop_q;

      if (accept) begin
         if (in_bcast) begin
            pend_d = '1;
            data_d = in_data;
         end else if (sel_ok) begin
            pend_d = sel_onehot;
            data_d = in_data;
         end else begin
            // Bad select: the word is swallowed, the old payload is kept.
            pend_d = '0;
            if (drop_q != 8'hFF) begin
               drop_d = drop_q + 8'd1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_q <= '0;
         data_q <= '0;
         drop_q <= '0;
      end else begin
         pend_q <= pend_d;
         data_q <= data_d;
         drop_q <= drop_d;
      end
   end

   assign out_valid = pend_q;
   assign out_data  = data_q;
   assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_demux_1xn_stream.sv
// Purpose : self-checking bench for demux_1xn_stream (8-channel and 5-channel builds).
// Latency : expects outputs one cycle after each accept.
// Backpr. : drives per-channel out_ready patterns, including staggered release.
module tb_demux_1xn_stream;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;

   // 8-channel instance
   logic       in_valid  = 1'b0;
   logic       in_ready;
   logic [7:0] in_data   = 8'h00;
   logic [2:0] in_sel    = 3'd0;
   logic       in_bcast  = 1'b0;
   logic [7:0] out_valid;
   logic [7:0] out_ready = 8'h00;
   logic [7:0] out_data;
   logic [7:0] drop_cnt;

   // 5-channel instance (out-of-range selects exist)
   logic       b_valid     = 1'b0;
   logic       b_ready;
   logic [7:0] b_data      = 8'h00;
   logic [2:0] b_sel       = 3'd0;
   logic       b_bcast     = 1'b0;
   logic [4:0] b_out_valid;
   logic [4:0] b_out_ready = 5'h1F;
   logic [7:0] b_out_data;
   logic [7:0] b_drop;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   demux_1xn_stream #(.DATA_W(8), .N_OUT(8), .SEL_W(3)) dut8 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_sel(in_sel), .in_bcast(in_bcast),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .drop_cnt(drop_cnt)
   );

   demux_1xn_stream #(.DATA_W(8), .N_OUT(5), .SEL_W(3)) dut5 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(b_valid), .in_ready(b_ready), .in_data(b_data),
      .in_sel(b_sel), .in_bcast(b_bcast),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
      .drop_cnt(b_drop)
   );

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%02h, expected 0x%02h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- scoreboard for the 8-channel instance ----------------
   typedef struct packed {
      logic [7:0] data;
      logic [7:0] mask;
   } word_t;

   word_t      sb_q[$];
   logic       mon_en = 1'b0;
   logic [7:0] m_rem;
   logic       m_exp_rdy;
   word_t      m_w;

   // Samples 2 time units before each rising edge, after inputs have settled.
   always begin
      @(negedge clk);
      #3;
      if (mon_en && rst_n) begin
         m_rem = (sb_q.size() != 0) ? sb_q[0].mask : 8'h00;
         chk("sb_out_valid", out_valid, m_rem);
         if (m_rem != 8'h00) chk("sb_out_data", out_data, sb_q[0].data);
         m_exp_rdy = ((m_rem & ~out_ready) == 8'h00);
         chk("sb_in_ready", 8'(in_ready), 8'(m_exp_rdy));
         if (m_rem != 8'h00) begin
            m_w = sb_q.pop_front();
            if ((m_rem & ~out_ready) != 8'h00) begin
               m_w.mask = m_rem & ~out_ready;
               sb_q.push_front(m_w);
            end
         end
         if (in_valid && m_exp_rdy) begin
            m_w.data = in_data;
            m_w.mask = in_bcast ? 8'hFF : (8'h01 << in_sel);
            sb_q.push_back(m_w);
         end
      end
   end

   task automatic drive(input logic v, input logic [2:0] s, input logic b,
                        input logic [7:0] d, input logic [7:0] rdy);
      @(negedge clk);
      in_valid  = v;
      in_sel    = s;
      in_bcast  = b;
      in_data   = d;
      out_ready = rdy;
   endtask

   task automatic drive_b(input logic v, input logic [2:0] s, input logic b, input logic [7:0] d);
      @(negedge clk);
      b_valid = v;
      b_sel   = s;
      b_bcast = b;
      b_data  = d;
   endtask

   typedef struct {
      logic       v;
      logic [2:0] sel;
      logic       b;
      logic [7:0] d;
      logic [7:0] rdy;
      logic       exp_rdy;
      logic [7:0] exp_vld;
      logic [7:0] exp_dat;
   } vec_t;

   vec_t vec[10];

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] ones;
      int         exp_drop;

      for (int i = 0; i < 8; i++) begin
         vec[i] = '{1'b1, 3'(i), 1'b0, 8'hA5, 8'hFF, 1'b1, 8'(1 << i), 8'hA5};
      end
      vec[8] = '{1'b1, 3'd5, 1'b1, 8'h5A, 8'hFF, 1'b1, 8'hFF, 8'h5A};
      vec[9] = '{1'b0, 3'd2, 1'b0, 8'hEE, 8'hFF, 1'b1, 8'h00, 8'h5A};

      // Reset state, checked while rst_n is still low.
      #2;
      chk("rst_out_valid", out_valid, 8'h00);
      chk("rst_out_data", out_data, 8'h00);
      chk("rst_drop_cnt", drop_cnt, 8'h00);
      chk("rst_in_ready", 8'(in_ready), 8'h01);
      chk("rst_b_out_valid", 8'(b_out_valid), 8'h00);
      @(negedge clk);
      #2 rst_n = 1'b1;
      mon_en = 1'b1;

      // Table: unicast sweep, full-rate broadcast, idle drain.
      for (int i = 0; i < 10; i++) begin
         drive(vec[i].v, vec[i].sel, vec[i].b, vec[i].d, vec[i].rdy);
         #2;
         chk("vec_in_ready", 8'(in_ready), 8'(vec[i].exp_rdy));
         @(posedge clk);
         #1;
         chk("vec_out_valid", out_valid, vec[i].exp_vld);
         chk("vec_out_data", out_data, vec[i].exp_dat);
      end

      // Backpressure on channel 3 with a second word queued.
      drive(1'b1, 3'd3, 1'b0, 8'h11, 8'hF7);
      @(posedge clk);
      #1;
      chk("bp_first", out_valid, 8'h08);
      for (int k = 0; k < 4; k++) begin
         drive(1'b1, 3'd5, 1'b0, 8'h22, 8'hF7);
         #2;
         chk("bp_in_ready_low", 8'(in_ready), 8'h00);
         @(posedge clk);
         #1;
         chk("bp_hold_valid", out_valid, 8'h08);
         chk("bp_hold_data", out_data, 8'h11);
      end
      drive(1'b1, 3'd5, 1'b0, 8'h22, 8'hFF);
      #2;
      chk("bp_release_ready", 8'(in_ready), 8'h01);
      @(posedge clk);
      #1;
      chk("bp_second_valid", out_valid, 8'h20);
      chk("bp_second_data", out_data, 8'h22);
      drive(1'b0, 3'd0, 1'b0, 8'h00, 8'hFF);

      // Staggered broadcast: consumers release one channel per cycle.
      drive(1'b1, 3'd1, 1'b1, 8'h3C, 8'h00);
      @(posedge clk);
      #1;
      chk("stag_start", out_valid, 8'hFF);
      for (int k = 0; k < 8; k++) begin
         drive(1'b0, 3'd0, 1'b0, 8'h00, 8'((2 << k) - 1));
         #2;
         chk("stag_in_ready", 8'(in_ready), (k == 7) ? 8'h01 : 8'h00);
         chk("stag_data", out_data, 8'h3C);
         @(posedge clk);
         #1;
         ones = 8'hFF;
         chk("stag_pend", out_valid, ones << (k + 1));
      end

      // Out-of-range selects on the 5-channel build.
      drive_b(1'b1, 3'd4, 1'b0, 8'h44);
      @(posedge clk);
      #1;
      chk("b_last_legal_valid", 8'(b_out_valid), 8'h10);
      chk("b_last_legal_data", b_out_data, 8'h44);
      chk("b_last_legal_drop", b_drop, 8'h00);
      drive_b(1'b1, 3'd5, 1'b0, 8'h55);
      #2;
      chk("b_in_ready", 8'(b_ready), 8'h01);
      @(posedge clk);
      #1;
      chk("b_first_bad_valid", 8'(b_out_valid), 8'h00);
      chk("b_first_bad_data", b_out_data, 8'h44);
      chk("b_first_bad_drop", b_drop, 8'h01);
      exp_drop = 1;
      for (int k = 0; k < 299; k++) begin
         drive_b(1'b1, 3'd6, 1'b0, 8'(k));
         @(posedge clk);
         #1;
         exp_drop = (exp_drop < 255) ? exp_drop + 1 : 255;
         chk("b_drop_valid", 8'(b_out_valid), 8'h00);
         chk("b_drop_cnt", b_drop, 8'(exp_drop));
      end
      chk("b_drop_saturated", b_drop, 8'hFF);
      drive_b(1'b1, 3'd7, 1'b1, 8'hBC);
      @(posedge clk);
      #1;
      chk("b_bcast_valid", 8'(b_out_valid), 8'h1F);
      chk("b_bcast_data", b_out_data, 8'hBC);
      chk("b_bcast_drop", b_drop, 8'hFF);
      drive_b(1'b0, 3'd0, 1'b0, 8'h00);

      // Reset in the middle of a held broadcast.
      drive(1'b1, 3'd0, 1'b1, 8'h77, 8'hF0);
      drive(1'b0, 3'd0, 1'b0, 8'h00, 8'hF0);
      @(posedge clk);
      #1;
      chk("rmid_pend", out_valid, 8'h0F);
      @(negedge clk);
      out_ready = 8'h00;
      #1 rst_n = 1'b0;
      #1;
      chk("rmid_out_valid", out_valid, 8'h00);
      chk("rmid_out_data", out_data, 8'h00);
      chk("rmid_drop", drop_cnt, 8'h00);
      chk("rmid_b_drop", b_drop, 8'h00);
      chk("rmid_in_ready", 8'(in_ready), 8'h01);
      sb_q.delete();
      in_valid  = 1'b1;
      in_sel    = 3'd6;
      in_bcast  = 1'b0;
      in_data   = 8'h99;
      out_ready = 8'hFF;
      rst_n     = 1'b1;
      @(posedge clk);
      #1;
      chk("rpost_valid", out_valid, 8'h40);
      chk("rpost_data", out_data, 8'h99);
      drive(1'b0, 3'd0, 1'b0, 8'h00, 8'hFF);
      drive(1'b0, 3'd0, 1'b0, 8'h00, 8'hFF);
      @(posedge clk);
      #1;
      chk("sb_drained", 8'(sb_q.size()), 8'h00);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
